booth_mac_r4: RTL and testbench

Parametrised radix-4 Booth multiplier-accumulator, the successor to the fixed 8-bit Booth multiplier in the arithmetic library. It takes any even operand width and supports the same per-operand signed/unsigned modes. It adds valid/ready handshakes on both sides, a one-entry output buffer that absorbs back-pressure, and an optional accumulate mode. It sits between the operand-fetch stage and the writeback stage of the DSP datapath.

---
 rtl/booth_pkg.sv | 33 +++
 rtl/booth_r4_sel.sv | 30 +++
 rtl/booth_mac_r4.sv | 148 ++++++++++++++
 tb/tb_booth_mac_r4.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiply-accumulate unit.
// Digits are coded sign-magnitude as {neg, two, one}.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] D_ZERO = 3'b000;
    localparam logic [2:0] D_P1   = 3'b001;
    localparam logic [2:0] D_P2   = 3'b010;
    localparam logic [2:0] D_M1   = 3'b101;
    localparam logic [2:0] D_M2   = 3'b110;

    function automatic int booth_iters(input int width);
        return width / 2 + 1;
    endfunction

    function automatic logic [2:0] booth_digit(input logic [2:0] win);
        logic [2:0] d;
        case (win)
            3'b001, 3'b010: d = D_P1;
            3'b011:         d = D_P2;
            3'b100:         d = D_M2;
            3'b101, 3'b110: d = D_M1;
            default:        d = D_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product select: picks 0/1x/2x and inverts for
// negative digits; the caller adds neg as carry-in to finish the negation.
module booth_r4_sel
    import booth_pkg::*;
#(
    parameter int W = 11
) (
    input  logic [2:0]   window,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic [W-1:0] addend,
    output logic         neg
);

    logic [2:0]   dig;
    logic [W-1:0] mag;

    always_comb begin
        dig = booth_digit(window);
        mag = '0;
        unique case (1'b1)
            dig[1]:  mag = x2;
            dig[0]:  mag = x1;
            default: mag = '0;
        endcase
        neg    = dig[2];
        addend = neg ? ~mag : mag;
    end

endmodule

// File: rtl/booth_mac_r4.sv
// Iterative radix-4 Booth multiplier-accumulator with valid/ready on both
// sides and a one-entry output buffer that absorbs back-pressure.
module booth_mac_r4
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [1:0]         sign_mode,
    input  logic               accumulate,
    input  logic               acc_clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int N  = booth_iters(WIDTH);
    localparam int XW = WIDTH + 3;
    localparam int LW = 2 * N + 1;
    localparam int PW = XW + LW;
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(N + 1);

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [PW-1:0]  prod_q;
    logic [XW-1:0]  x1_q;
    logic           acc_flag_q;
    logic [RW-1:0]  acc_q;

    logic           sa;
    logic           sb;
    logic [XW-1:0]  a_ext;
    logic [2*N-1:0] b_ext;
    logic [XW-1:0]  x2;
    logic [XW-1:0]  addend;
    logic           neg;
    logic [XW-1:0]  hi_sum;
    logic [PW-1:0]  prod_nx;
    logic [RW-1:0]  product;
    logic [RW-1:0]  final_val;
    logic [RW-1:0]  load_val;
    logic           buf_free;
    logic           done;
    logic           load_buf;

    assign sa    = sign_mode[1] & multiplicand[WIDTH-1];
    assign sb    = sign_mode[0] & multiplier[WIDTH-1];
    assign a_ext = {{3{sa}}, multiplicand};
    assign b_ext = {{(2*N-WIDTH){sb}}, multiplier};
    assign x2    = {x1_q[XW-2:0], 1'b0};

    booth_r4_sel #(
        .W(XW)
    ) u_sel (
        .window (prod_q[2:0]),
        .x1     (x1_q),
        .x2     (x2),
        .addend (addend),
        .neg    (neg)
    );

    // Upper half takes the addend, then the whole register shifts by one digit.
    always_comb begin
        hi_sum  = prod_q[PW-1:LW] + addend + XW'(neg);
        prod_nx = PW'($signed({hi_sum, prod_q[LW-1:0]}) >>> 2);
    end

    assign product   = prod_q[RW:1];
    assign final_val = acc_flag_q ? acc_q + product : product;
    assign buf_free  = ~out_valid | out_ready;
    assign done      = (state_q == CALC) && (cnt_q == CW'(N));
    assign load_buf  = buf_free & (done | (state_q == HOLD));
    assign load_val  = (state_q == HOLD) ? acc_q : final_val;

    assign in_ready = rst_n & (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = CALC;
            CALC: if (done) state_d = buf_free ? IDLE : HOLD;
            HOLD: if (buf_free) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD reuses acc_q as the pending result, since completion already wrote it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            prod_q     <= '0;
            x1_q       <= '0;
            acc_flag_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (acc_clear) acc_q <= '0;
                    if (in_valid) begin
                        cnt_q      <= '0;
                        x1_q       <= a_ext;
                        prod_q     <= {{XW{1'b0}}, b_ext, 1'b0};
                        acc_flag_q <= accumulate;
                    end
                end
                CALC: begin
                    if (done) begin
                        acc_q <= final_val;
                    end else begin
                        prod_q <= prod_nx;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (load_buf) begin
            out_valid <= 1'b1;
            result    <= load_val;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_mac_r4.sv
// Directed bench for booth_mac_r4 at WIDTH=8, plus a short randomised
// sequential run against a behavioural multiply model.
module tb_booth_mac_r4;

    localparam int W = 8;
    localparam int N = W / 2 + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [1:0]     sign_mode = 2'b00;
    logic           accumulate = 1'b0;
    logic           acc_clear = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] result;
    logic           busy;

    int passed = 0;
    int total  = 0;

    booth_mac_r4 #(
        .WIDTH(W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .sign_mode    (sign_mode),
        .accumulate   (accumulate),
        .acc_clear    (acc_clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] m, input logic ac,
                        input logic cl);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("send_timeout", 32'(in_ready), 32'd1);
        multiplicand = a;
        multiplier   = b;
        sign_mode    = m;
        accumulate   = ac;
        acc_clear    = cl;
        in_valid     = 1'b1;
        tick();
        in_valid     = 1'b0;
        acc_clear    = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic get_result(output logic [2*W-1:0] r, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        r = result;
        if (out_ready) tick();
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [1:0] m);
        logic signed [31:0] ae;
        logic signed [31:0] be;
        logic signed [31:0] p;
        ae = m[1] ? 32'(signed'(a)) : {24'b0, a};
        be = m[0] ? 32'(signed'(b)) : {24'b0, b};
        p  = ae * be;
        return p[2*W-1:0];
    endfunction

    initial begin
        logic [2*W-1:0] r;
        logic [2*W-1:0] exp_r;
        logic [2*W-1:0] macc;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [1:0]     rm;
        logic           rac;
        logic           rcl;
        int             lat;
        int             pulses;
        int             e;
        bit             got;

        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_after", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        send(8'h80, 8'h80, 2'b11, 1'b0, 1'b0);
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_in_ready", 32'(in_ready), 32'd0);
        get_result(r, lat);
        check("lat_m128sq", 32'(lat), 32'(N + 1));
        check("res_m128sq", 32'(r), 32'h4000);
        check("one_beat", 32'(out_valid), 32'd0);

        send(8'hFF, 8'hFF, 2'b00, 1'b0, 1'b0);
        get_result(r, lat);
        check("res_uu_255sq", 32'(r), 32'hFE01);

        send(8'hFF, 8'hFF, 2'b10, 1'b0, 1'b0);
        get_result(r, lat);
        check("res_su_m1x255", 32'(r), 32'hFF01);

        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        send(8'd3, 8'd4, 2'b11, 1'b1, 1'b0);
        get_result(r, lat);
        check("acc_3x4", 32'(r), 32'd12);
        send(8'd5, 8'd6, 2'b11, 1'b1, 1'b0);
        get_result(r, lat);
        check("acc_plus_5x6", 32'(r), 32'd42);
        send(8'd2, 8'd2, 2'b11, 1'b0, 1'b0);
        get_result(r, lat);
        check("noacc_2x2", 32'(r), 32'd4);
        send(8'd1, 8'd1, 2'b11, 1'b1, 1'b1);
        get_result(r, lat);
        check("clear_with_op", 32'(r), 32'd1);

        out_ready = 1'b0;
        send(8'd2, 8'd3, 2'b11, 1'b0, 1'b0);
        get_result(r, lat);
        check("bp_op1", 32'(r), 32'd6);
        send(8'd4, 8'd5, 2'b11, 1'b0, 1'b0);
        repeat (N + 1) tick();
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_valid", 32'(out_valid), 32'd1);
        repeat (2) tick();
        check("hold_stable", 32'(result), 32'd6);
        out_ready = 1'b1;
        tick();
        check("op2_valid", 32'(out_valid), 32'd1);
        check("op2_result", 32'(result), 32'd20);
        check("op2_idle", 32'(in_ready), 32'd1);
        tick();
        check("op2_drained", 32'(out_valid), 32'd0);

        send(8'd9, 8'd9, 2'b11, 1'b1, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            if (out_valid) pulses++;
            tick();
        end
        check("abort_no_valid", 32'(pulses), 32'd0);
        send(8'd7, 8'hFD, 2'b11, 1'b1, 1'b0);
        get_result(r, lat);
        check("post_rst_7xm3", 32'(r), 32'hFFEB);

        macc = 16'hFFEB;
        for (int i = 0; i < 300; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rm  = 2'($urandom);
            rac = 1'($urandom);
            rcl = ($urandom_range(0, 7) == 0);
            if (rcl) macc = '0;
            exp_r = model(ra, rb, rm) + (rac ? macc : '0);
            macc  = exp_r;
            send(ra, rb, rm, rac, rcl);
            e   = 0;
            got = 1'b0;
            while (!got && e < 80) begin
                out_ready = 1'($urandom);
                #1;
                if (in_ready && busy) check("rnd_ready_busy", 32'd1, 32'd0);
                if (out_valid && out_ready) begin
                    check("rnd_result", 32'(result), 32'(exp_r));
                    got = 1'b1;
                end
                tick();
                e++;
            end
            if (!got) check("rnd_timeout", 32'(got), 32'd1);
        end
        out_ready = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
